// File: rtl/jt89_noise_gen_if.sv
// jt89_noise_gen_if: register-write bus from the PSG decoder into the noise channel
interface jt89_noise_gen_if;
  logic       ctrl_wr;
  logic [2:0] ctrl;
  logic       vol_wr;
  logic [3:0] vol;
  modport master(output ctrl_wr, ctrl, vol_wr, vol);
  modport slave(input ctrl_wr, ctrl, vol_wr, vol);
endinterface

// File: rtl/jt89_noise_gen.sv
// jt89_noise_gen: JT89 noise channel, rate-selected LFSR scaled by attenuation
// JT89_NOISE15_EN selects the 15-bit TI LFSR instead of the 16-bit Sega one
module jt89_noise_gen (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              tone2_rise,
  jt89_noise_gen_if.slave   bus,
  output logic signed [9:0] noise
);
`ifdef JT89_NOISE15_EN
  localparam int W = 15;
  localparam int TAP = 1;
  localparam logic [W-1:0] SEED = 15'h4000;
`else
  localparam int W = 16;
  localparam int TAP = 3;
  localparam logic [W-1:0] SEED = 16'h8000;
`endif
  localparam logic [8:0] AMP [16] = '{9'd511, 9'd406, 9'd322, 9'd256, 9'd203, 9'd161, 9'd128, 9'd102,
                                      9'd81, 9'd64, 9'd51, 9'd40, 9'd32, 9'd26, 9'd20, 9'd0};
  logic [2:0] ctrl_q, ctrl_d;
  logic [3:0] vol_q, vol_d;
  logic [6:0] cnt_q, cnt_d;
  logic [W-1:0] lfsr_q, lfsr_d;
  logic signed [9:0] noise_q, noise_d;
  logic [6:0] last;
  logic [8:0] amp;
  logic tone_rate, tick, shift, fb;
  always_comb begin
    tone_rate = &ctrl_q[1:0];
    last = ctrl_q[1] ? 7'd127 : ctrl_q[0] ? 7'd63 : 7'd31;
    tick = clk_en && cnt_q == last;
    shift = tone_rate ? tone2_rise : tick;
    fb = lfsr_q[0] ^ (ctrl_q[2] & lfsr_q[TAP]);
    amp = AMP[vol_q];
    noise_d = lfsr_q[0] ? $signed({1'b0, amp}) : -$signed({1'b0, amp});
    // a control write reseeds and restarts the period, dropping any coincident shift
    cnt_d = (tone_rate || bus.ctrl_wr) ? 7'd0 : clk_en ? (tick ? 7'd0 : cnt_q + 7'd1) : cnt_q;
    lfsr_d = bus.ctrl_wr ? SEED : shift ? {fb, lfsr_q[W-1:1]} : lfsr_q;
    ctrl_d = bus.ctrl_wr ? bus.ctrl : ctrl_q;
    vol_d = bus.vol_wr ? bus.vol : vol_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= 3'd0;
      vol_q <= 4'hF;
      cnt_q <= 7'd0;
      lfsr_q <= SEED;
      noise_q <= 10'sd0;
    end else begin
      ctrl_q <= ctrl_d;
      vol_q <= vol_d;
      cnt_q <= cnt_d;
      lfsr_q <= lfsr_d;
      noise_q <= noise_d;
    end
  end
  assign noise = noise_q;
endmodule
